// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 PWM gate generator and commutation logic.
// State encodings, gate bit positions, commutation step codes and the
// step-to-gate-pattern decode.
package motoro3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // gate_o bit order is {AH,AL,BH,BL,CH,CL}
    localparam int unsigned GATE_AH = 5;
    localparam int unsigned GATE_AL = 4;
    localparam int unsigned GATE_BH = 3;
    localparam int unsigned GATE_BL = 2;
    localparam int unsigned GATE_CH = 1;
    localparam int unsigned GATE_CL = 0;

    // Keeps only the low-side bits; used to blank the high side outside its on-window.
    localparam logic [5:0] GATE_LOW_MASK = 6'b010101;

    localparam logic [3:0] STEP_COAST = 4'd0;
    localparam logic [3:0] STEP_1     = 4'd1;
    localparam logic [3:0] STEP_2     = 4'd2;
    localparam logic [3:0] STEP_3     = 4'd3;
    localparam logic [3:0] STEP_4     = 4'd4;
    localparam logic [3:0] STEP_5     = 4'd5;
    localparam logic [3:0] STEP_6     = 4'd6;

    // Full gate pattern (high and low side both on) for a commutation step.
    function automatic logic [5:0] step2gate(input logic [3:0] s);
        logic [5:0] g;
        g = '0;
        case (s)
            STEP_1:     begin g[GATE_AH] = 1'b1; g[GATE_BL] = 1'b1; end
            STEP_2:     begin g[GATE_AH] = 1'b1; g[GATE_CL] = 1'b1; end
            STEP_3:     begin g[GATE_BH] = 1'b1; g[GATE_CL] = 1'b1; end
            STEP_4:     begin g[GATE_BH] = 1'b1; g[GATE_AL] = 1'b1; end
            STEP_5:     begin g[GATE_CH] = 1'b1; g[GATE_AL] = 1'b1; end
            STEP_6:     begin g[GATE_CH] = 1'b1; g[GATE_BL] = 1'b1; end
            STEP_COAST: g = '0;
            default:    g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/motoro3_pwm_counter.sv
// PWM period counter: owns cnt, wrap detection and the period_start pulse.
// MOTORO3_PWM_CENTER_ALIGNED_EN selects an up/down (centre-aligned) count;
// otherwise the counter is an edge-aligned up-counter.
module motoro3_pwm_counter #(
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        run,
    input  logic [11:0] per_s,
    output logic [11:0] cnt,
    output logic        wrap,
    output logic        period_start
);

    localparam logic [11:0] MIN_PER = 12'(MIN_PERIOD);

    logic [11:0] cnt_q;
    logic [11:0] per_m1;
    logic        per_bad;
    logic        wrap_raw;

    assign per_m1  = per_s - 12'd1;
    assign per_bad = per_s < MIN_PER;
    assign cnt     = cnt_q;

`ifdef MOTORO3_PWM_CENTER_ALIGNED_EN
    logic down_q;

    // Period ends on the down-count just before reaching 0 (per_s=2 has no down leg).
    always_comb begin
        if (down_q) begin
            wrap_raw = cnt_q <= 12'd1;
        end else begin
            wrap_raw = (cnt_q >= per_m1) && (per_m1 <= 12'd1);
        end
        // An illegal period is re-checked every cycle so a fix is picked up at once.
        wrap = run && (per_bad || wrap_raw);
    end

    // Up/down count; held at 0 counting up whenever not running.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (!run || wrap) begin
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (!down_q && (cnt_q >= per_m1)) begin
            cnt_q  <= per_m1 - 12'd1;
            down_q <= 1'b1;
        end else if (down_q) begin
            cnt_q <= cnt_q - 12'd1;
        end else begin
            cnt_q <= cnt_q + 12'd1;
        end
    end
`else
    // Edge-aligned: period ends at per_s-1; illegal period wraps every cycle.
    always_comb begin
        wrap_raw = cnt_q >= per_m1;
        wrap     = run && (per_bad || wrap_raw);
    end

    // Up-count; held at 0 whenever not running.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else if (!run || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 12'd1;
        end
    end
`endif

    // Pulse coincides with cnt=0 of the new period; suppressed while the period is illegal.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= run && wrap && !per_bad;
        end
    end

endmodule

// File: rtl/motoro3_pwm_gate_gen.sv
// 3-phase bridge gate generator: chops the high side at the PWM rate, holds
// the low side per commutation step and inserts dead-time on step changes.
// Optional macro MOTORO3_PWM_CENTER_ALIGNED_EN selects centre-aligned PWM.
module motoro3_pwm_gate_gen
    import motoro3_pkg::*;
#(
    parameter int unsigned DEAD_CYC   = 8,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic [11:0] pwm_len,
    input  logic [11:0] pwm_period,
    input  logic [3:0]  step,
    output logic [5:0]  gate_o,
    output logic        period_start,
    output logic        cfg_err,
    output logic [1:0]  state_o
);

    localparam logic [7:0]  DEAD_INIT = 8'(DEAD_CYC);
    localparam logic [11:0] MIN_PER   = 12'(MIN_PERIOD);

    state_e      state;
    logic [11:0] len_s;
    logic [11:0] per_s;
    logic [3:0]  step_s;
    logic [7:0]  deadcnt;

    logic [11:0] cnt;
    logic        wrap;
    logic        run;
    logic        per_bad;
    logic        hi_on;
    logic [5:0]  run_gate;

    assign run     = (state == ST_RUN) && en;
    assign per_bad = per_s < MIN_PER;
    assign cfg_err = (state == ST_RUN) && per_bad;
    assign state_o = state;

    motoro3_pwm_counter #(
        .MIN_PERIOD (MIN_PERIOD)
    ) u_counter (
        .clk          (clk),
        .nRst         (nRst),
        .run          (run),
        .per_s        (per_s),
        .cnt          (cnt),
        .wrap         (wrap),
        .period_start (period_start)
    );

    // High-side on-window for the current count, then mask the step pattern.
    always_comb begin
`ifdef MOTORO3_PWM_CENTER_ALIGNED_EN
        hi_on = (len_s >= per_s) || (cnt >= (per_s - len_s));
`else
        hi_on = cnt < len_s;
`endif
        run_gate = step2gate(step_s) & (hi_on ? 6'h3F : GATE_LOW_MASK);
    end

    // Control FSM with shadow registers and the registered gate outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= ST_IDLE;
            gate_o  <= '0;
            len_s   <= '0;
            per_s   <= '0;
            step_s  <= '0;
            deadcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gate_o <= '0;
                    if (en) begin
                        len_s   <= pwm_len;
                        per_s   <= pwm_period;
                        step_s  <= step;
                        deadcnt <= DEAD_INIT;
                        state   <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    gate_o <= '0;
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        deadcnt <= deadcnt - 8'd1;
                        if (deadcnt <= 8'd1) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        gate_o <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        // Last cycle of the old pattern still drives; DEAD blanks after it.
                        gate_o <= per_bad ? 6'h00 : run_gate;
                        if (wrap) begin
                            len_s <= pwm_len;
                            per_s <= pwm_period;
                            if (step != step_s) begin
                                step_s  <= step;
                                deadcnt <= DEAD_INIT;
                                state   <= ST_DEAD;
                            end
                        end
                    end
                end
                default: begin
                    gate_o <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // A phase's high and low switches must never conduct together.
    a_no_shoot_through: assert property (@(posedge clk) disable iff (!nRst)
        !(gate_o[GATE_AH] && gate_o[GATE_AL]) &&
        !(gate_o[GATE_BH] && gate_o[GATE_BL]) &&
        !(gate_o[GATE_CH] && gate_o[GATE_CL]));

endmodule

// File: tb/tb_motoro3_pwm_gate_gen.sv
// Directed bench for motoro3_pwm_gate_gen (edge-aligned build, DEAD_CYC=8).
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_motoro3_pwm_gate_gen;

    localparam logic [5:0] AH = 6'b100000;
    localparam logic [5:0] BH = 6'b001000;
    localparam logic [5:0] BL = 6'b000100;
    localparam logic [5:0] CL = 6'b000001;

    logic        clk = 1'b0;
    logic        nRst;
    logic        en;
    logic [11:0] pwm_len;
    logic [11:0] pwm_period;
    logic [3:0]  step;
    logic [5:0]  gate_o;
    logic        period_start;
    logic        cfg_err;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motoro3_pwm_gate_gen #(
        .DEAD_CYC   (8),
        .MIN_PERIOD (2)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .pwm_len      (pwm_len),
        .pwm_period   (pwm_period),
        .step         (step),
        .gate_o       (gate_o),
        .period_start (period_start),
        .cfg_err      (cfg_err),
        .state_o      (state_o)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Return to IDLE, then raise en; the next falling edge is sample 0.
    task automatic start_run(input logic [11:0] len, input logic [11:0] per,
                             input logic [3:0] st);
        en = 1'b0;
        tick();
        tick();
        pwm_len    = len;
        pwm_period = per;
        step       = st;
        en         = 1'b1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; en = 1'b0; pwm_len = '0; pwm_period = '0; step = '0;
        tick();
        tick();
        checks++; if (gate_o !== 6'h00) begin errors++; $display("FAIL reset_gate got %b want %b", gate_o, 6'h00); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_pstart got %b want 0", period_start); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        nRst = 1'b1;
    endtask

    // Samples 0..208: dead time, then two periods of len=25 out of 100.
    task automatic test_basic();
        logic [5:0] exp;
        logic       exp_ps;
        int         ph;
        start_run(12'd25, 12'd100, 4'd1);
        for (int s = 0; s <= 208; s++) begin
            tick();
            if (s <= 8) exp = 6'h00;
            else begin
                ph  = (s - 9) % 100;
                exp = BL | ((ph < 25) ? AH : 6'h00);
            end
            exp_ps = (s == 108) || (s == 208);
            checks++; if (gate_o !== exp) begin errors++; $display("FAIL basic_gate s=%0d got %b want %b", s, gate_o, exp); end
            checks++; if (period_start !== exp_ps) begin errors++; $display("FAIL basic_pstart s=%0d got %b want %b", s, period_start, exp_ps); end
            if (s == 0 || s == 7) begin
                checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL basic_state_dead s=%0d got %0d want 1", s, state_o); end
            end
            if (s == 8) begin
                checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL basic_state_run s=%0d got %0d want 2", s, state_o); end
            end
        end
    endtask

    // len changes 25->60 when cnt=40 (sample 248); takes effect after the wrap at 308.
    task automatic test_len_change();
        logic [5:0] exp;
        logic       exp_ps;
        int         ph;
        int         lc;
        for (int s = 209; s <= 408; s++) begin
            tick();
            ph     = (s - 9) % 100;
            lc     = (s <= 308) ? 25 : 60;
            exp    = BL | ((ph < lc) ? AH : 6'h00);
            exp_ps = (s == 308) || (s == 408);
            checks++; if (gate_o !== exp) begin errors++; $display("FAIL len_change_gate s=%0d got %b want %b", s, gate_o, exp); end
            checks++; if (period_start !== exp_ps) begin errors++; $display("FAIL len_change_pstart s=%0d got %b want %b", s, period_start, exp_ps); end
            if (s == 248) pwm_len = 12'd60;
        end
    endtask

    // Step 1->2 mid-period: pattern 1 to the wrap, 8 blank cycles, then AH/CL.
    task automatic test_step_change();
        logic [5:0] exp;
        logic       exp_ps;
        int         ph;
        for (int s = 409; s <= 620; s++) begin
            tick();
            if (s <= 508) begin
                ph  = (s - 9) % 100;
                exp = BL | ((ph < 60) ? AH : 6'h00);
            end else if (s <= 516) begin
                exp = 6'h00;
            end else begin
                ph  = (s - 517) % 100;
                exp = CL | ((ph < 60) ? AH : 6'h00);
            end
            exp_ps = (s == 508) || (s == 616);
            checks++; if (gate_o !== exp) begin errors++; $display("FAIL step_change_gate s=%0d got %b want %b", s, gate_o, exp); end
            checks++; if (period_start !== exp_ps) begin errors++; $display("FAIL step_change_pstart s=%0d got %b want %b", s, period_start, exp_ps); end
            if (s == 508 || s == 515) begin
                checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL step_change_dead s=%0d got %0d want 1", s, state_o); end
            end
            if (s == 516) begin
                checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL step_change_run s=%0d got %0d want 2", s, state_o); end
            end
            if (s == 430) step = 4'd2;
        end
    endtask

    // len=0 never drives the high side; len=per_s and len=4095 drive it all period.
    task automatic test_len_bounds();
        logic [11:0] lens [3];
        logic [5:0]  exp;
        lens[0] = 12'd0; lens[1] = 12'd100; lens[2] = 12'd4095;
        for (int k = 0; k < 3; k++) begin
            start_run(lens[k], 12'd100, 4'd3);
            for (int s = 0; s <= 208; s++) begin
                tick();
                if (s >= 9) begin
                    exp = (k == 0) ? CL : (BH | CL);
                    checks++; if (gate_o !== exp) begin errors++; $display("FAIL len_bound_gate len=%0d s=%0d got %b want %b", lens[k], s, gate_o, exp); end
                end
            end
        end
    endtask

    // period=1 flags cfg_err with gates off; restoring 100 resumes PWM immediately.
    task automatic test_cfg_err();
        logic [5:0] exp;
        logic       exp_ps;
        start_run(12'd25, 12'd1, 4'd1);
        for (int s = 0; s <= 140; s++) begin
            tick();
            if (s >= 8 && s <= 30) begin
                checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set s=%0d got %b want 1", s, cfg_err); end
                checks++; if (gate_o !== 6'h00) begin errors++; $display("FAIL cfg_err_gate s=%0d got %b want %b", s, gate_o, 6'h00); end
                checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL cfg_err_pstart s=%0d got %b want 0", s, period_start); end
            end
            if (s >= 31) begin
                exp    = (s == 31) ? 6'h00 : (BL | ((((s - 32) % 100) < 25) ? AH : 6'h00));
                exp_ps = (s == 131);
                checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear s=%0d got %b want 0", s, cfg_err); end
                checks++; if (gate_o !== exp) begin errors++; $display("FAIL cfg_resume_gate s=%0d got %b want %b", s, gate_o, exp); end
                checks++; if (period_start !== exp_ps) begin errors++; $display("FAIL cfg_resume_pstart s=%0d got %b want %b", s, period_start, exp_ps); end
            end
            if (s == 30) pwm_period = 12'd100;
        end
    endtask

    // Continues from test_cfg_err with AH on: dropping en blanks gates on the next edge.
    task automatic test_en_drop();
        en = 1'b0;
        for (int s = 141; s <= 144; s++) begin
            tick();
            checks++; if (gate_o !== 6'h00) begin errors++; $display("FAIL en_drop_gate s=%0d got %b want %b", s, gate_o, 6'h00); end
            checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL en_drop_state s=%0d got %0d want 0", s, state_o); end
        end
    endtask

    // nRst clears outputs without a clock edge, both in RUN and mid-DEAD.
    task automatic test_async_reset();
        logic [5:0] exp;
        start_run(12'd25, 12'd100, 4'd1);
        for (int s = 0; s <= 11; s++) tick();
        checks++; if (gate_o !== (AH | BL)) begin errors++; $display("FAIL areset_pre_gate got %b want %b", gate_o, AH | BL); end
        #2 nRst = 1'b0;
        #1;
        checks++; if (gate_o !== 6'h00) begin errors++; $display("FAIL areset_run_gate got %b want %b", gate_o, 6'h00); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL areset_run_state got %0d want 0", state_o); end
        tick();
        nRst = 1'b1;
        for (int s = 0; s <= 3; s++) tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL areset_pre_dead got %0d want 1", state_o); end
        #2 nRst = 1'b0;
        #1;
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL areset_dead_state got %0d want 0", state_o); end
        checks++; if (gate_o !== 6'h00) begin errors++; $display("FAIL areset_dead_gate got %b want %b", gate_o, 6'h00); end
        tick();
        nRst = 1'b1;
        for (int s = 0; s <= 9; s++) begin
            tick();
            exp = (s <= 8) ? 6'h00 : (AH | BL);
            checks++; if (gate_o !== exp) begin errors++; $display("FAIL areset_recover s=%0d got %b want %b", s, gate_o, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_change();
        test_step_change();
        test_len_bounds();
        test_cfg_err();
        test_en_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
